// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon sequence player.
package simon_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StWaitSeq,
        StShowOn,
        StShowOff,
        StInput,
        StNext,
        StWin,
        StLose
    } state_e;

    localparam int unsigned MAX_ROUNDS = 4;
    localparam int unsigned STEP_W     = 2;

    function automatic logic [3:0] colour_onehot(input logic [1:0] colour);
        return 4'b0001 << colour;
    endfunction

endpackage

// File: rtl/simon_tick_timer.sv
// Interval timer: counts up from 0 after a load and flags the terminal count limit_i-1.
module simon_tick_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] limit_i,
    output logic             done_o
);

    logic [Width-1:0] count_q, count_d;

    assign done_o = (count_q == limit_i - Width'(1));

    // Hold at terminal count so a long-lived state never wraps back to zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (!done_o) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/simon_sequence_player.sv
// Simon game engine: latches a 4-step colour sequence, replays rounds 1..4 and checks presses.
// Define SIMON_TIMEOUT_EN to make an idle INPUT phase lose after TIMEOUT_TICKS cycles.
module simon_sequence_player
    import simon_pkg::*;
#(
    parameter int unsigned ON_TICKS      = 25_000_000,
    parameter int unsigned OFF_TICKS     = 12_500_000,
    parameter int unsigned TIMEOUT_TICKS = 300_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] seq_in,
    input  logic [3:0] buttons,
    output logic       seq_load,
    output logic [3:0] leds,
    output logic [2:0] round,
    output logic       busy,
    output logic       win,
    output logic       lose
);

    localparam int unsigned MaxShow = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
`ifdef SIMON_TIMEOUT_EN
    localparam int unsigned MaxTicks = (MaxShow > TIMEOUT_TICKS) ? MaxShow : TIMEOUT_TICKS;
`else
    localparam int unsigned MaxTicks = MaxShow;
`endif
    localparam int unsigned TimerW = $clog2(MaxTicks) + 1;

    if (ON_TICKS == 0 || OFF_TICKS == 0 || TIMEOUT_TICKS == 0) begin : g_bad_ticks
        $error("simon_sequence_player: tick parameters must be nonzero");
    end

    state_e              state_q, state_d;
    logic [7:0]          seq_q, seq_d;
    logic [2:0]          round_q, round_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                start_q;
    logic                start_edge;
    logic                step_is_last;
    logic [3:0]          step_colour;
    logic                timer_load;
    logic                timer_done;
    logic [TimerW-1:0]   timer_limit;

    assign start_edge   = start & ~start_q;
    assign step_is_last = ({1'b0, step_q} == round_q - 3'd1);
    assign step_colour  = colour_onehot(seq_q[{step_q, 1'b0} +: 2]);

    always_comb begin
        timer_limit = TimerW'(ON_TICKS);
        case (state_q)
            StShowOff: timer_limit = TimerW'(OFF_TICKS);
`ifdef SIMON_TIMEOUT_EN
            StInput:   timer_limit = TimerW'(TIMEOUT_TICKS);
`endif
            default:   timer_limit = TimerW'(ON_TICKS);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        round_d    = round_q;
        step_d     = step_q;
        seq_load   = 1'b0;
        leds       = 4'b0000;
        timer_load = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_edge) state_d = StLoad;
            end
            StLoad: begin
                seq_load = 1'b1;
                state_d  = StWaitSeq;
            end
            StWaitSeq: begin
                seq_d   = seq_in;
                round_d = 3'd1;
                step_d  = '0;
                state_d = StShowOn;
            end
            StShowOn: begin
                leds = step_colour;
                if (timer_done) state_d = StShowOff;
            end
            StShowOff: begin
                if (timer_done) begin
                    if (step_is_last) begin
                        step_d  = '0;
                        state_d = StInput;
                    end else begin
                        step_d  = step_q + STEP_W'(1);
                        state_d = StShowOn;
                    end
                end
            end
            StInput: begin
                // A press is evaluated before the timeout so a same-cycle press wins.
                if (buttons != 4'b0000) begin
                    if (buttons == step_colour) begin
                        if (step_is_last) begin
                            state_d = StNext;
                        end else begin
                            step_d     = step_q + STEP_W'(1);
                            timer_load = 1'b1;
                        end
                    end else begin
                        state_d = StLose;
                    end
                end
`ifdef SIMON_TIMEOUT_EN
                else if (timer_done) begin
                    state_d = StLose;
                end
`endif
            end
            StNext: begin
                if (round_q == 3'(MAX_ROUNDS)) begin
                    state_d = StWin;
                end else begin
                    round_d = round_q + 3'd1;
                    step_d  = '0;
                    state_d = StShowOn;
                end
            end
            StWin, StLose: begin
                if (start_edge) state_d = StLoad;
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) timer_load = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            seq_q   <= '0;
            round_q <= '0;
            step_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            round_q <= round_d;
            step_q  <= step_d;
            start_q <= start;
        end
    end

    simon_tick_timer #(
        .Width (TimerW)
    ) u_timer (
        .clk_i   (clock),
        .rst_i   (reset),
        .load_i  (timer_load),
        .limit_i (timer_limit),
        .done_o  (timer_done)
    );

    assign round = round_q;
    assign busy  = (state_q != StIdle) && (state_q != StWin) && (state_q != StLose);
    assign win   = (state_q == StWin);
    assign lose  = (state_q == StLose);

endmodule

// File: tb/tb_simon_sequence_player.sv
// Scoreboard bench for simon_sequence_player: per-cycle expected outputs queued by stimulus.
module tb_simon_sequence_player;

    typedef struct packed {
        logic       seq_load;
        logic [3:0] leds;
        logic [2:0] round;
        logic       busy;
        logic       win;
        logic       lose;
    } obs_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] seq_in;
    logic [3:0] buttons;
    logic       seq_load;
    logic [3:0] leds;
    logic [2:0] round;
    logic       busy;
    logic       win;
    logic       lose;

    obs_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    localparam logic [7:0] SeqA = 8'b11_10_01_00;
    localparam logic [7:0] SeqB = 8'b00_01_11_10;

    simon_sequence_player #(
        .ON_TICKS      (4),
        .OFF_TICKS     (2),
        .TIMEOUT_TICKS (10)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .seq_in   (seq_in),
        .buttons  (buttons),
        .seq_load (seq_load),
        .leds     (leds),
        .round    (round),
        .busy     (busy),
        .win      (win),
        .lose     (lose)
    );

    always #5 clock = ~clock;

    // Monitor: every cycle with a queued expectation, compare the observed outputs.
    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            obs_t  e;
            obs_t  a;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {seq_load, leds, round, busy, win, lose};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s @%0t: got seq_load=%b leds=%b round=%0d busy=%b win=%b lose=%b, required seq_load=%b leds=%b round=%0d busy=%b win=%b lose=%b",
                         t, $time, a.seq_load, a.leds, a.round, a.busy, a.win, a.lose,
                         e.seq_load, e.leds, e.round, e.busy, e.win, e.lose);
            end
        end
    end

    function automatic obs_t idle_o();
        return {1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0};
    endfunction
    function automatic obs_t busy_o(input logic [2:0] r, input logic [3:0] l);
        return {1'b0, l, r, 1'b1, 1'b0, 1'b0};
    endfunction
    function automatic obs_t load_o(input logic [2:0] r);
        return {1'b1, 4'b0000, r, 1'b1, 1'b0, 1'b0};
    endfunction
    function automatic obs_t win_o();
        return {1'b0, 4'b0000, 3'd4, 1'b0, 1'b1, 1'b0};
    endfunction
    function automatic obs_t lose_o(input logic [2:0] r);
        return {1'b0, 4'b0000, r, 1'b0, 1'b0, 1'b1};
    endfunction
    function automatic logic [3:0] col_led(input logic [7:0] s, input int k);
        logic [1:0] c;
        c = s[2*k +: 2];
        return 4'b0001 << c;
    endfunction

    // Queue the outputs expected during the current cycle, apply buttons, advance one clock.
    task automatic tick(input obs_t e, input string tag, input logic [3:0] btn);
        buttons = btn;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
        buttons = 4'b0000;
    endtask

    task automatic start_game(input obs_t prev, input logic [2:0] prev_round, input logic [7:0] s);
        seq_in = s;
        start  = 1'b1;
        tick(prev, "pre_start", 4'b0000);
        start  = 1'b0;
        tick(load_o(prev_round), "seq_load", 4'b0000);
        tick(busy_o(prev_round, 4'b0000), "wait_seq", 4'b0000);
        seq_in = ~s;
    endtask

    task automatic show_round(input int r, input logic [7:0] s, input bit noise);
        for (int k = 0; k < r; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (noise && c == 1) start = 1'b1;
                tick(busy_o(3'(r), col_led(s, k)), "show_on",
                     (noise && c == 0) ? 4'b1001 : 4'b0000);
                start = 1'b0;
            end
            for (int c = 0; c < 2; c++) tick(busy_o(3'(r), 4'b0000), "show_off", 4'b0000);
        end
    endtask

    task automatic play_round(input int r, input logic [7:0] s);
        show_round(r, s, 1'b0);
        for (int k = 0; k < r; k++) begin
            if (k == 1) tick(busy_o(3'(r), 4'b0000), "input_wait", 4'b0000);
            tick(busy_o(3'(r), 4'b0000), "input_press", col_led(s, k));
        end
        tick(busy_o(3'(r), 4'b0000), "next", 4'b0000);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        seq_in  = 8'h00;
        buttons = 4'b0000;
        @(posedge clock);
        #1;
        tick(idle_o(), "reset_state", 4'b0000);
        reset = 1'b0;
        tick(idle_o(), "idle", 4'b0000);

        // Reset in the middle of a shown step.
        start_game(idle_o(), 3'd0, SeqA);
        tick(busy_o(3'd1, 4'b0001), "show_on", 4'b0000);
        reset = 1'b1;
        tick(busy_o(3'd1, 4'b0001), "show_on_rst", 4'b0000);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick(idle_o(), "after_reset", 4'b0000);

        // Full winning game; presses in WIN are ignored.
        start_game(idle_o(), 3'd0, SeqA);
        for (int r = 1; r <= 4; r++) play_round(r, SeqA);
        tick(win_o(), "win", 4'b0010);
        tick(win_o(), "win_hold", 4'b0000);
        tick(win_o(), "win_hold", 4'b0000);

        // Wrong colour in round 2.
        start_game(win_o(), 3'd4, SeqA);
        play_round(1, SeqA);
        show_round(2, SeqA, 1'b0);
        tick(busy_o(3'd2, 4'b0000), "input_press", 4'b0001);
        tick(busy_o(3'd2, 4'b0000), "input_wrong", 4'b0100);
        tick(lose_o(3'd2), "lose", 4'b0000);
        tick(lose_o(3'd2), "lose_hold", 4'b0000);

        // Noise during replay is ignored; multi-hot press loses.
        start_game(lose_o(3'd2), 3'd2, SeqB);
        show_round(1, SeqB, 1'b1);
        tick(busy_o(3'd1, 4'b0000), "input_press", 4'b0100);
        tick(busy_o(3'd1, 4'b0000), "next", 4'b0000);
        show_round(2, SeqB, 1'b0);
        tick(busy_o(3'd2, 4'b0000), "input_multi", 4'b0011);
        tick(lose_o(3'd2), "lose_multi", 4'b0000);

        // INPUT inactivity.
        start_game(lose_o(3'd2), 3'd2, SeqA);
        play_round(1, SeqA);
        show_round(2, SeqA, 1'b0);
`ifdef SIMON_TIMEOUT_EN
        for (int i = 0; i < 9; i++) tick(busy_o(3'd2, 4'b0000), "to_wait", 4'b0000);
        tick(busy_o(3'd2, 4'b0000), "to_press_at_expiry", 4'b0001);
        for (int i = 0; i < 10; i++) tick(busy_o(3'd2, 4'b0000), "to_reloaded", 4'b0000);
        tick(lose_o(3'd2), "timeout_lose", 4'b0000);
`else
        for (int i = 0; i < 1000; i++) tick(busy_o(3'd2, 4'b0000), "no_timeout", 4'b0000);
        tick(busy_o(3'd2, 4'b0000), "input_press", 4'b0001);
        tick(busy_o(3'd2, 4'b0000), "input_press", 4'b0010);
        tick(busy_o(3'd2, 4'b0000), "next", 4'b0000);
        tick(busy_o(3'd3, 4'b0001), "show_on", 4'b0000);
`endif

        @(negedge clock);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
